// File: rtl/forward_key_expansion.sv
// forward_key_expansion
// Sequential AES-128 key-schedule engine. A cipher key is latched on start and
// the engine then presents round keys 0..NUM_ROUNDS, one per accepted
// valid/ready handshake. It uses the forward S-box for SubWord. It feeds the
// encryption AddRoundKey stage and can preload a decryption key store.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-high reset
//   start      load key_in and begin a schedule (sampled only while idle)
//   key_in     128-bit cipher key, byte 0 in [127:120]
//   busy       high from the cycle after start until the final key is taken
//   rk_valid   round_key / rk_index hold a valid round key
//   rk_ready   consumer accepts the round key on rk_valid && rk_ready
//   rk_index   round number of round_key (0..NUM_ROUNDS)
//   round_key  current round key, w[4i] in [127:96]
//   done       one-cycle pulse after the final round key is accepted
module forward_key_expansion #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [3:0]   rk_index,
   output logic [127:0] round_key,
   output logic         done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   state_t       state, nextstate;
   logic [7:0]   rcon, nextrcon;
   logic         nextbusy, nextvalid, nextdone;
   logic [3:0]   nextindex;
   logic [127:0] nextkey;
   logic [31:0]  rotated, subbed, temp;
   logic [31:0]  n0, n1, n2, n3;
   logic [127:0] expanded;

   // One key-schedule step: RotWord/SubWord/Rcon on the last word, then the
   // running xor chain across the four words of the current round key.
   always_comb begin
      rotated  = {round_key[23:0], round_key[31:24]};
      subbed   = {SBOX[rotated[31:24]], SBOX[rotated[23:16]],
                  SBOX[rotated[15:8]],  SBOX[rotated[7:0]]};
      temp     = subbed ^ {rcon, 24'h0};
      n0       = round_key[127:96] ^ temp;
      n1       = round_key[95:64]  ^ n0;
      n2       = round_key[63:32]  ^ n1;
      n3       = round_key[31:0]   ^ n2;
      expanded = {n0, n1, n2, n3};
   end

   // Next-state and next-output logic. Every output is registered, so this
   // block computes the values that appear one cycle later. In RUN rk_valid is
   // always high, so a handshake only needs rk_ready.
   always_comb begin
      nextstate = state;
      nextbusy  = busy;
      nextvalid = rk_valid;
      nextindex = rk_index;
      nextkey   = round_key;
      nextrcon  = rcon;
      nextdone  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextstate = RUN;
               nextbusy  = 1'b1;
               nextvalid = 1'b1;
               nextindex = 4'd0;
               nextkey   = key_in;
               nextrcon  = 8'h01;
            end
         end
         RUN: begin
            if (rk_ready) begin
               if (rk_index == 4'(NUM_ROUNDS)) begin
                  nextstate = IDLE;
                  nextbusy  = 1'b0;
                  nextvalid = 1'b0;
                  nextdone  = 1'b1;
               end else begin
                  nextkey   = expanded;
                  nextindex = rk_index + 4'd1;
                  nextrcon  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               end
            end
         end
         default: nextstate = IDLE;
      endcase
   end

   // State and output registers; reset abandons any schedule in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         rk_valid  <= 1'b0;
         rk_index  <= 4'd0;
         round_key <= 128'h0;
         done      <= 1'b0;
         rcon      <= 8'h01;
      end else begin
         state     <= nextstate;
         busy      <= nextbusy;
         rk_valid  <= nextvalid;
         rk_index  <= nextindex;
         round_key <= nextkey;
         done      <= nextdone;
         rcon      <= nextrcon;
      end
   end

endmodule

// File: tb/tb_forward_key_expansion.sv
// tb_forward_key_expansion
// Self-checking bench for forward_key_expansion. A word-level key-expansion
// model (S-box derived from the GF(2^8) inverse plus affine map) predicts every
// round key; a transaction model tracks valid/busy/done/index and a compare
// process checks the DUT against it on every falling edge. Literal vectors
// pin the model and the DUT at selected rounds.
module tb_forward_key_expansion;

   localparam int NR = 10;
   typedef logic [10:0][127:0] keys_t;

   localparam logic [127:0] FIPSKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] SBKEY   = 128'h00000000000000000000000058127a0d;
   localparam logic [127:0] SBKEY1  = 128'hc8dad76ac8dad76ac8dad76a90c8ad67;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key_in = 128'h0;
   logic         rk_ready = 1'b1;
   logic         busy, rk_valid, done;
   logic [3:0]   rk_index;
   logic [127:0] round_key;

   int checks = 0;
   int failures = 0;

   logic [7:0] msb [0:255];

   logic         mbusy = 1'b0;
   logic         mvalid = 1'b0;
   logic         mdone = 1'b0;
   logic [3:0]   midx = 4'd0;
   logic [127:0] mround = 128'h0;
   keys_t        mkeys;

   forward_key_expansion #(.NUM_ROUNDS(NR)) dut (
      .clk(clk), .reset(reset), .start(start), .key_in(key_in),
      .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
      .rk_index(rk_index), .round_key(round_key), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] sboxMath(input logic [7:0] x);
      logic [7:0]  inv = 8'h0;
      logic [15:0] d;
      for (int y = 1; y < 256; y++)
         if (x != 8'h0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
   endfunction

   // FIPS-197 word-oriented expansion: w[i] = w[i-4] ^ f(w[i-1]).
   function automatic keys_t expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      keys_t       k;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {msb[t[31:24]], msb[t[23:16]], msb[t[15:8]], msb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return k;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model of the handshake protocol.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mbusy <= 1'b0; mvalid <= 1'b0; mdone <= 1'b0; midx <= 4'd0; mround <= 128'h0;
      end else begin
         mdone <= 1'b0;
         if (!mbusy) begin
            if (start) begin
               mkeys <= expand(key_in);
               mbusy <= 1'b1; mvalid <= 1'b1; midx <= 4'd0; mround <= key_in;
            end
         end else if (rk_ready) begin
            if (midx == 4'(NR)) begin
               mbusy <= 1'b0; mvalid <= 1'b0; mdone <= 1'b1;
            end else begin
               midx   <= midx + 4'd1;
               mround <= mkeys[midx + 4'd1];
            end
         end
      end
   end

   // Compare process: every falling edge, DUT versus model.
   always @(negedge clk) begin
      checkOutput("busy", busy, mbusy);
      checkOutput("rk_valid", rk_valid, mvalid);
      checkOutput("done", done, mdone);
      checkOutput("rk_index", rk_index, midx);
      checkOutput("round_key", round_key, mround);
   end

   task automatic applyStimulus(input logic [127:0] key);
      @(negedge clk);
      start = 1'b1; key_in = key;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Consume one schedule from the current index-0 cycle until done.
   task automatic runSchedule(input logic [127:0] key, input logic [127:0] lit1,
                              input logic [127:0] lit10, input bit stall, input bit doStart);
      int seen = 0;
      int doneCyc = -1;
      bit gotDone = 1'b0;
      if (doStart) applyStimulus(key);
      for (int cyc = 0; cyc < 100 && !gotDone; cyc++) begin
         rk_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
         if (done) begin
            gotDone = 1'b1;
            doneCyc = cyc;
         end else if (rk_valid && rk_ready) begin
            checkOutput("seq_index", rk_index, seen);
            if (rk_index == 4'd1) checkOutput("rk1_literal", round_key, lit1);
            if (rk_index == 4'd10) checkOutput("rk10_literal", round_key, lit10);
            seen++;
         end
         if (!gotDone) @(negedge clk);
      end
      rk_ready = 1'b1;
      checkOutput("keys_accepted", seen, 11);
      checkOutput("done_seen", gotDone, 1);
      if (!stall) checkOutput("done_cycle", doneCyc, 11);
   endtask

   initial begin
      keys_t k;
      for (int i = 0; i < 256; i++) msb[i] = sboxMath(8'(i));

      checkOutput("model_sbox_12", msb[8'h12], 8'hc9);
      checkOutput("model_sbox_7a", msb[8'h7a], 8'hda);
      checkOutput("model_sbox_0d", msb[8'h0d], 8'hd7);
      checkOutput("model_sbox_58", msb[8'h58], 8'h6a);
      k = expand(FIPSKEY);
      checkOutput("model_fips_rk1", k[1], FIPS1);
      checkOutput("model_fips_rk10", k[10], FIPS10);
      k = expand(128'h0);
      checkOutput("model_zero_rk1", k[1], ZERO1);
      checkOutput("model_zero_rk10", k[10], ZERO10);
      k = expand(SBKEY);

      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_valid", rk_valid, 0);
      checkOutput("reset_key", round_key, 128'h0);

      $display("[TB] SubWord spot-check key");
      runSchedule(SBKEY, SBKEY1, k[10], 1'b0, 1'b1);

      $display("[TB] FIPS-197 key, continuous ready");
      runSchedule(FIPSKEY, FIPS1, FIPS10, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("done_falls", done, 0);

      $display("[TB] FIPS-197 key, backpressure");
      runSchedule(FIPSKEY, FIPS1, FIPS10, 1'b1, 1'b1);

      $display("[TB] start pulsed mid-schedule");
      applyStimulus(FIPSKEY);
      repeat (3) @(negedge clk);
      start = 1'b1; key_in = 128'h0;
      @(negedge clk);
      start = 1'b0; key_in = 128'hffffffffffffffffffffffffffffffff;
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      checkOutput("midstart_done", done, 1);
      checkOutput("midstart_final", round_key, FIPS10);

      $display("[TB] reset at rk_index 5");
      applyStimulus(FIPSKEY);
      for (int i = 0; i < 40 && !(rk_valid && rk_index == 4'd5); i++) @(negedge clk);
      checkOutput("reached_idx5", rk_index, 5);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort_valid", rk_valid, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_key", round_key, 128'h0);
      checkOutput("abort_index", rk_index, 0);
      @(negedge clk);
      reset = 1'b0;
      runSchedule(FIPSKEY, FIPS1, FIPS10, 1'b0, 1'b1);

      $display("[TB] back-to-back start in done cycle");
      start = 1'b1; key_in = 128'h0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_valid", rk_valid, 1);
      checkOutput("b2b_index", rk_index, 0);
      checkOutput("b2b_key", round_key, 128'h0);
      checkOutput("b2b_done", done, 0);
      runSchedule(128'h0, ZERO1, ZERO10, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
